// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I pipeline: forwarding operand muxes, ALU,
// branch resolution and the EX/MEM pipeline register.
// Optional feature macro: EX_MUL_EN adds single-cycle RV32M MUL on ALU op 4'b1011.
// Without EX_MUL_EN, op 4'b1011 returns 0 and no multiplier is built.
module ex_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_ex_valid,
   input  logic [XLEN-1:0] id_ex_pc,
   input  logic [XLEN-1:0] id_ex_rs1_data,
   input  logic [XLEN-1:0] id_ex_rs2_data,
   input  logic [XLEN-1:0] id_ex_imm,
   input  logic [4:0]      id_ex_rd,
   input  logic [3:0]      id_ex_alu_op,
   input  logic            id_ex_alu_src,
   input  logic            id_ex_branch,
   input  logic [2:0]      id_ex_funct3,
   input  logic            id_ex_regwrite,
   input  logic            id_ex_memread,
   input  logic            id_ex_memwrite,
   input  logic            id_ex_memtoreg,
   input  logic [1:0]      forwardA,
   input  logic [1:0]      forwardB,
   input  logic [XLEN-1:0] wb_data,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_target,
   output logic            ex_mem_valid,
   output logic            ex_mem_regwrite,
   output logic            ex_mem_memread,
   output logic            ex_mem_memwrite,
   output logic            ex_mem_memtoreg,
   output logic [4:0]      ex_mem_rd,
   output logic [XLEN-1:0] ex_mem_alu_result,
   output logic [XLEN-1:0] ex_mem_store_data,
   output logic [XLEN-1:0] ex_mem_pc
);

   localparam logic [3:0] AluAdd   = 4'b0000;
   localparam logic [3:0] AluSub   = 4'b0001;
   localparam logic [3:0] AluSll   = 4'b0010;
   localparam logic [3:0] AluSlt   = 4'b0011;
   localparam logic [3:0] AluSltu  = 4'b0100;
   localparam logic [3:0] AluXor   = 4'b0101;
   localparam logic [3:0] AluSrl   = 4'b0110;
   localparam logic [3:0] AluSra   = 4'b0111;
   localparam logic [3:0] AluOr    = 4'b1000;
   localparam logic [3:0] AluAnd   = 4'b1001;
   localparam logic [3:0] AluPassB = 4'b1010;
   localparam logic [3:0] AluMul   = 4'b1011;

   logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;
   logic [4:0]      shamt;
   logic            br_cond;

   logic            valid_q, valid_d;
   logic            regwrite_q, regwrite_d;
   logic            memread_q, memread_d;
   logic            memwrite_q, memwrite_d;
   logic            memtoreg_q, memtoreg_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] alu_result_q, alu_result_d;
   logic [XLEN-1:0] store_data_q, store_data_d;
   logic [XLEN-1:0] pc_q, pc_d;

   // Forwarding muxes; select 2'b11 falls back to the register-file value.
   always_comb begin
      case (forwardA)
         2'b10:   fwd_a = alu_result_q;
         2'b01:   fwd_a = wb_data;
         default: fwd_a = id_ex_rs1_data;
      endcase
      case (forwardB)
         2'b10:   fwd_b = alu_result_q;
         2'b01:   fwd_b = wb_data;
         default: fwd_b = id_ex_rs2_data;
      endcase
   end

   assign op_b  = id_ex_alu_src ? id_ex_imm : fwd_b;
   assign shamt = op_b[4:0];

   // ALU result; unused opcodes produce zero.
   always_comb begin
      alu_res = '0;
      case (id_ex_alu_op)
         AluAdd:   alu_res = fwd_a + op_b;
         AluSub:   alu_res = fwd_a - op_b;
         AluSll:   alu_res = fwd_a << shamt;
         AluSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
         AluSltu:  alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
         AluXor:   alu_res = fwd_a ^ op_b;
         AluSrl:   alu_res = fwd_a >> shamt;
         AluSra:   alu_res = $unsigned($signed(fwd_a) >>> shamt);
         AluOr:    alu_res = fwd_a | op_b;
         AluAnd:   alu_res = fwd_a & op_b;
         AluPassB: alu_res = op_b;
`ifdef EX_MUL_EN
         AluMul:   alu_res = fwd_a * op_b;
`else
         AluMul:   alu_res = '0;
`endif
         default:  alu_res = '0;
      endcase
   end

   // Branch condition compares the forwarded register values, never the immediate.
   always_comb begin
      br_cond = 1'b0;
      case (id_ex_funct3)
         3'b000:  br_cond = (fwd_a == fwd_b);
         3'b001:  br_cond = (fwd_a != fwd_b);
         3'b100:  br_cond = ($signed(fwd_a) <  $signed(fwd_b));
         3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
         3'b110:  br_cond = (fwd_a <  fwd_b);
         3'b111:  br_cond = (fwd_a >= fwd_b);
         default: br_cond = 1'b0;
      endcase
   end

   assign branch_taken  = id_ex_valid & id_ex_branch & br_cond & ~flush;
   assign branch_target = id_ex_pc + id_ex_imm;

   // EX/MEM next state: flush beats stall; flush clears control but holds data.
   always_comb begin
      valid_d      = valid_q;
      regwrite_d   = regwrite_q;
      memread_d    = memread_q;
      memwrite_d   = memwrite_q;
      memtoreg_d   = memtoreg_q;
      rd_d         = rd_q;
      alu_result_d = alu_result_q;
      store_data_d = store_data_q;
      pc_d         = pc_q;
      if (flush) begin
         valid_d    = 1'b0;
         regwrite_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         memtoreg_d = 1'b0;
      end else if (!stall) begin
         valid_d      = id_ex_valid;
         regwrite_d   = id_ex_valid & id_ex_regwrite;
         memread_d    = id_ex_valid & id_ex_memread;
         memwrite_d   = id_ex_valid & id_ex_memwrite;
         memtoreg_d   = id_ex_valid & id_ex_memtoreg;
         rd_d         = id_ex_rd;
         alu_result_d = alu_res;
         store_data_d = fwd_b;
         pc_d         = id_ex_pc;
      end
   end

   // EX/MEM pipeline register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         regwrite_q   <= 1'b0;
         memread_q    <= 1'b0;
         memwrite_q   <= 1'b0;
         memtoreg_q   <= 1'b0;
         rd_q         <= '0;
         alu_result_q <= '0;
         store_data_q <= '0;
         pc_q         <= RESET_PC;
      end else begin
         valid_q      <= valid_d;
         regwrite_q   <= regwrite_d;
         memread_q    <= memread_d;
         memwrite_q   <= memwrite_d;
         memtoreg_q   <= memtoreg_d;
         rd_q         <= rd_d;
         alu_result_q <= alu_result_d;
         store_data_q <= store_data_d;
         pc_q         <= pc_d;
      end
   end

   assign ex_mem_valid      = valid_q;
   assign ex_mem_regwrite   = regwrite_q;
   assign ex_mem_memread    = memread_q;
   assign ex_mem_memwrite   = memwrite_q;
   assign ex_mem_memtoreg   = memtoreg_q;
   assign ex_mem_rd         = rd_q;
   assign ex_mem_alu_result = alu_result_q;
   assign ex_mem_store_data = store_data_q;
   assign ex_mem_pc         = pc_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: forwarding, ALU ops, branches, stall/flush
// and asynchronous reset, with hand-computed expected values.
module tb_ex_stage;

   localparam logic [31:0] RstPc = 32'h0000_1000;

   logic        clk, rst_n, stall, flush;
   logic        id_ex_valid, id_ex_alu_src, id_ex_branch;
   logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, wb_data;
   logic [4:0]  id_ex_rd;
   logic [3:0]  id_ex_alu_op;
   logic [2:0]  id_ex_funct3;
   logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg;
   logic [1:0]  forwardA, forwardB;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        ex_mem_valid, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite;
   logic        ex_mem_memtoreg;
   logic [4:0]  ex_mem_rd;
   logic [31:0] ex_mem_alu_result, ex_mem_store_data, ex_mem_pc;

   int n_checks = 0;
   int n_errors = 0;

   ex_stage #(
      .XLEN     (32),
      .RESET_PC (RstPc)
   ) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .stall             (stall),
      .flush             (flush),
      .id_ex_valid       (id_ex_valid),
      .id_ex_pc          (id_ex_pc),
      .id_ex_rs1_data    (id_ex_rs1_data),
      .id_ex_rs2_data    (id_ex_rs2_data),
      .id_ex_imm         (id_ex_imm),
      .id_ex_rd          (id_ex_rd),
      .id_ex_alu_op      (id_ex_alu_op),
      .id_ex_alu_src     (id_ex_alu_src),
      .id_ex_branch      (id_ex_branch),
      .id_ex_funct3      (id_ex_funct3),
      .id_ex_regwrite    (id_ex_regwrite),
      .id_ex_memread     (id_ex_memread),
      .id_ex_memwrite    (id_ex_memwrite),
      .id_ex_memtoreg    (id_ex_memtoreg),
      .forwardA          (forwardA),
      .forwardB          (forwardB),
      .wb_data           (wb_data),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .ex_mem_valid      (ex_mem_valid),
      .ex_mem_regwrite   (ex_mem_regwrite),
      .ex_mem_memread    (ex_mem_memread),
      .ex_mem_memwrite   (ex_mem_memwrite),
      .ex_mem_memtoreg   (ex_mem_memtoreg),
      .ex_mem_rd         (ex_mem_rd),
      .ex_mem_alu_result (ex_mem_alu_result),
      .ex_mem_store_data (ex_mem_store_data),
      .ex_mem_pc         (ex_mem_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU table: op, rs1, rs2 (alu_src = 0), expected result.
   localparam int NVec = 12;
   localparam logic [3:0] VOp [NVec] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1111};
   localparam logic [31:0] VA [NVec] = '{32'h0000_0003, 32'h0000_0001, 32'hFFFF_FFFF,
      32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h8000_0000, 32'h8000_0000, 32'hF0F0_F0F0,
      32'hF0F0_F0F0, 32'h0000_0001, 32'h0000_0005, 32'h0000_0005};
   localparam logic [31:0] VB [NVec] = '{32'h0000_0005, 32'h0000_0021, 32'h0000_0001,
      32'h0000_0001, 32'hFF00_FF00, 32'h0000_0004, 32'h0000_0004, 32'h0F0F_0000,
      32'hFF00_FF00, 32'h0000_1234, 32'h0000_0003, 32'h0000_0003};
   localparam logic [31:0] VE [NVec] = '{32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0001,
      32'h0000_0000, 32'h0FF0_0FF0, 32'h0800_0000, 32'hF800_0000, 32'hFFFF_F0F0,
      32'hF000_F000, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; flush = 0; id_ex_valid = 0; id_ex_pc = '0;
      id_ex_rs1_data = '0; id_ex_rs2_data = '0; id_ex_imm = '0; id_ex_rd = '0;
      id_ex_alu_op = '0; id_ex_alu_src = 0; id_ex_branch = 0; id_ex_funct3 = '0;
      id_ex_regwrite = 0; id_ex_memread = 0; id_ex_memwrite = 0; id_ex_memtoreg = 0;
      forwardA = 2'b00; forwardB = 2'b00; wb_data = '0;
   endtask

   task automatic alu_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      idle();
      id_ex_valid = 1; id_ex_regwrite = 1; id_ex_alu_op = op;
      id_ex_rs1_data = a; id_ex_rs2_data = b;
   endtask

   initial begin
      logic [31:0] mul_exp;
      idle();
      rst_n = 0;
      tick();
      tick();
      // Reset state
      check_eq("rst_valid", ex_mem_valid, 0);
      check_eq("rst_regwrite", ex_mem_regwrite, 0);
      check_eq("rst_memread", ex_mem_memread, 0);
      check_eq("rst_memwrite", ex_mem_memwrite, 0);
      check_eq("rst_memtoreg", ex_mem_memtoreg, 0);
      check_eq("rst_rd", ex_mem_rd, 0);
      check_eq("rst_alu", ex_mem_alu_result, 0);
      check_eq("rst_store", ex_mem_store_data, 0);
      check_eq("rst_pc", ex_mem_pc, RstPc);

      // Reset release mid-cycle: first capture on the next rising edge
      alu_instr(4'b0000, 32'd1, 32'd2);
      id_ex_rd = 5'd5; id_ex_pc = 32'h40;
      #3 rst_n = 1;
      tick();
      check_eq("rel_alu", ex_mem_alu_result, 32'd3);
      check_eq("rel_rd", ex_mem_rd, 5'd5);
      check_eq("rel_pc", ex_mem_pc, 32'h40);
      check_eq("rel_regwrite", ex_mem_regwrite, 1);
      check_eq("rel_valid", ex_mem_valid, 1);

      // Forwarding from EX/MEM: seed 0x10 then forwardA=10 ADD imm 3
      alu_instr(4'b1010, 32'd0, 32'd0);
      id_ex_alu_src = 1; id_ex_imm = 32'h10;
      tick();
      check_eq("seed_passb", ex_mem_alu_result, 32'h10);
      alu_instr(4'b0000, 32'd5, 32'd0);
      id_ex_alu_src = 1; id_ex_imm = 32'd3; forwardA = 2'b10;
      tick();
      check_eq("fwdA_exmem_add", ex_mem_alu_result, 32'h13);
      // forwardA=11 behaves as 00
      alu_instr(4'b0000, 32'd5, 32'd0);
      id_ex_alu_src = 1; id_ex_imm = 32'd3; forwardA = 2'b11; wb_data = 32'h100;
      tick();
      check_eq("fwdA_11", ex_mem_alu_result, 32'd8);

      // forwardB=01 to store data, with immediate as operand B
      alu_instr(4'b0000, 32'h100, 32'h55);
      id_ex_alu_src = 1; id_ex_imm = 32'd8; forwardB = 2'b01;
      wb_data = 32'hDEAD_BEEF; id_ex_memwrite = 1; id_ex_regwrite = 0;
      tick();
      check_eq("store_fwd_wb", ex_mem_store_data, 32'hDEAD_BEEF);
      check_eq("store_memwrite", ex_mem_memwrite, 1);
      check_eq("store_alu", ex_mem_alu_result, 32'h108);
      check_eq("store_regwrite", ex_mem_regwrite, 0);
      // forwardB=10 on the rs2 path
      alu_instr(4'b0000, 32'd1, 32'h77);
      forwardB = 2'b10; id_ex_memread = 1; id_ex_memtoreg = 1;
      tick();
      check_eq("fwdB_exmem_alu", ex_mem_alu_result, 32'h109);
      check_eq("fwdB_exmem_store", ex_mem_store_data, 32'h108);
      check_eq("load_memread", ex_mem_memread, 1);
      check_eq("load_memtoreg", ex_mem_memtoreg, 1);

      // Store data is rs2 even when operand B is the immediate
      alu_instr(4'b0000, 32'd2, 32'h0000_0ABC);
      id_ex_alu_src = 1; id_ex_imm = 32'h10;
      tick();
      check_eq("store_not_imm", ex_mem_store_data, 32'h0000_0ABC);
      check_eq("imm_add", ex_mem_alu_result, 32'h12);

      // ALU op table
      for (int i = 0; i < NVec; i++) begin
         alu_instr(VOp[i], VA[i], VB[i]);
         tick();
         check_eq($sformatf("alu_op%b", VOp[i]), ex_mem_alu_result, VE[i]);
      end
`ifdef EX_MUL_EN
      mul_exp = 32'h0003_0000;
`else
      mul_exp = 32'h0000_0000;
`endif
      alu_instr(4'b1011, 32'h0001_0000, 32'h0001_0003);
      tick();
      check_eq("alu_mul", ex_mem_alu_result, mul_exp);

      // Invalid instruction becomes a bubble
      alu_instr(4'b0000, 32'd1, 32'd1);
      id_ex_valid = 0; id_ex_memread = 1; id_ex_memwrite = 1; id_ex_memtoreg = 1;
      tick();
      check_eq("bub_valid", ex_mem_valid, 0);
      check_eq("bub_regwrite", ex_mem_regwrite, 0);
      check_eq("bub_memread", ex_mem_memread, 0);
      check_eq("bub_memwrite", ex_mem_memwrite, 0);
      check_eq("bub_memtoreg", ex_mem_memtoreg, 0);

      // Branches, checked combinationally in the same cycle
      idle();
      id_ex_valid = 1; id_ex_branch = 1; id_ex_pc = 32'h100; id_ex_imm = 32'h20;
      id_ex_rs1_data = 32'hFFFF_FFFF; id_ex_rs2_data = 32'd1; id_ex_funct3 = 3'b100;
      #1;
      check_eq("blt_taken", branch_taken, 1);
      check_eq("blt_target", branch_target, 32'h120);
      id_ex_funct3 = 3'b110; #1;
      check_eq("bltu_taken", branch_taken, 0);
      id_ex_funct3 = 3'b111; #1;
      check_eq("bgeu_taken", branch_taken, 1);
      id_ex_funct3 = 3'b101; #1;
      check_eq("bge_taken", branch_taken, 0);
      id_ex_funct3 = 3'b001; #1;
      check_eq("bne_taken", branch_taken, 1);
      id_ex_funct3 = 3'b010; #1;
      check_eq("f3_010_taken", branch_taken, 0);
      id_ex_funct3 = 3'b000; id_ex_rs2_data = 32'hFFFF_FFFF; #1;
      check_eq("beq_taken", branch_taken, 1);
      id_ex_alu_src = 1; id_ex_imm = 32'd7; #1;
      check_eq("beq_ignores_imm", branch_taken, 1);
      flush = 1; #1;
      check_eq("beq_flushed", branch_taken, 0);
      flush = 0; id_ex_valid = 0; #1;
      check_eq("beq_invalid", branch_taken, 0);
      id_ex_valid = 1; id_ex_branch = 0; #1;
      check_eq("beq_nobranch", branch_taken, 0);

      // Stall holds; the forward path sees the held result
      alu_instr(4'b0000, 32'd3, 32'd4);
      id_ex_rd = 5'd4;
      tick();
      check_eq("stall_seed", ex_mem_alu_result, 32'd7);
      alu_instr(4'b0000, 32'd100, 32'd0);
      id_ex_alu_src = 1; id_ex_imm = 32'd1; forwardA = 2'b10; id_ex_rd = 5'd9;
      id_ex_regwrite = 0; stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("stall_alu%0d", i), ex_mem_alu_result, 32'd7);
         check_eq($sformatf("stall_rd%0d", i), ex_mem_rd, 5'd4);
         check_eq($sformatf("stall_rw%0d", i), ex_mem_regwrite, 1);
      end
      stall = 0;
      tick();
      check_eq("post_stall_fwd", ex_mem_alu_result, 32'd8);
      check_eq("post_stall_rd", ex_mem_rd, 5'd9);
      // Reload valid regwrite, then stall+flush: flush wins
      alu_instr(4'b0000, 32'd3, 32'd4);
      tick();
      check_eq("pre_flush_rw", ex_mem_regwrite, 1);
      stall = 1; flush = 1;
      tick();
      check_eq("flush_valid", ex_mem_valid, 0);
      check_eq("flush_regwrite", ex_mem_regwrite, 0);

      // Async reset mid-cycle while regwrite is set
      alu_instr(4'b0000, 32'd5, 32'd6);
      id_ex_rd = 5'd3; id_ex_pc = 32'h88;
      tick();
      check_eq("arst_pre_rw", ex_mem_regwrite, 1);
      #2 rst_n = 0;
      #1;
      check_eq("arst_regwrite", ex_mem_regwrite, 0);
      check_eq("arst_valid", ex_mem_valid, 0);
      check_eq("arst_alu", ex_mem_alu_result, 0);
      check_eq("arst_rd", ex_mem_rd, 0);
      check_eq("arst_pc", ex_mem_pc, RstPc);
      tick();
      rst_n = 1;
      tick();
      check_eq("arst_recover", ex_mem_alu_result, 32'd11);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline.
- Consumes the ID/EX operands and the forwardA/forwardB selects from the forwarding unit, and selects the true operands.
- Performs ALU and branch-compare operations, resolves branches, and registers the results into the EX/MEM pipeline register.
- Its ex_mem_regwrite / ex_mem_rd / ex_mem_alu_result outputs feed back into the forwarding unit and its own operand muxes.

Parameters:
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, value loaded into ex_mem_pc on reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold EX/MEM register contents
- flush  in  1  load bubble into EX/MEM
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_pc  in  XLEN  instruction PC
- id_ex_rs1_data  in  XLEN  register-file rs1 value
- id_ex_rs2_data  in  XLEN  register-file rs2 value
- id_ex_imm  in  XLEN  sign-extended immediate
- id_ex_rd  in  5  destination register
- id_ex_alu_op  in  4  ALU operation code
- id_ex_alu_src  in  1  operand B: 0 = rs2 path, 1 = imm
- id_ex_branch  in  1  conditional branch
- id_ex_funct3  in  3  branch condition
- id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg  in  1 each  control bits
- forwardA, forwardB  in  2  forwarding selects
- wb_data  in  XLEN  write-back value (MEM/WB forward source)
- branch_taken  out  1  combinational: redirect fetch
- branch_target  out  XLEN  combinational: id_ex_pc + id_ex_imm
- ex_mem_valid, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg  out  1 each  registered control
- ex_mem_rd  out  5  registered destination
- ex_mem_alu_result  out  XLEN  registered ALU result
- ex_mem_store_data  out  XLEN  registered forwarded rs2 value
- ex_mem_pc  out  XLEN  registered PC

Behaviour:
- Operand select, forwardA and forwardB alike:
  - 00 → id_ex data
  - 10 → ex_mem_alu_result
  - 01 → wb_data
  - 11 → treated as 00
- opB = alu_src ? imm : forwarded rs2.
- Store data is always the forwarded rs2, never imm.
- ALU ops:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT (signed), 0100 SLTU
  - 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B
  - 1011 MUL (see Optional Feature)
  - 1100–1111 → 0
- Shift amount is opB[4:0]. Arithmetic wraps modulo 2^XLEN. SLT/SLTU produce 0 or 1, zero-extended.
- Branch compare uses the forwarded rs1 and rs2 (never imm):
  - funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
  - 010 and 011 → not taken
- branch_taken = id_ex_valid & id_ex_branch & cond & ~flush. Zero latency, combinational.
- EX/MEM register, evaluated at the rising edge in priority order:
  1. rst_n low (async): all outputs 0, ex_mem_pc = RESET_PC.
  2. flush: ex_mem_valid, regwrite, memread, memwrite and memtoreg = 0; data fields don't-care (implementation holds them).
  3. stall: all EX/MEM outputs hold.
  4. Otherwise capture:
     - control bits are gated by id_ex_valid, so an invalid instruction produces a bubble;
     - ex_mem_rd = id_ex_rd.
- flush and stall asserted together: flush wins.
- Latency: one cycle from ID/EX inputs to EX/MEM outputs.
- rd = 0 with regwrite = 1 is passed through unchanged; x0 suppression is done downstream.
- Reset deassertion mid-stream: the first capture happens at the first rising edge with rst_n high.
- During stall, the forward path from ex_mem_alu_result reflects the held value.

Optional Feature:
- Macro: EX_MUL_EN
- Defined: ALU op 1011 returns the low XLEN bits of opA*opB (RV32M MUL), single cycle.
- Undefined: op 1011 returns 0 and no multiplier is synthesised.

Test Plan:
- Forwarding: ex_mem_alu_result=32'h10, forwardA=10, rs1_data=5, imm=3, alu_src=1, ADD → next-cycle ex_mem_alu_result=32'h13.
- Forward source 01 and store data: forwardB=01, wb_data=32'hDEAD_BEEF, memwrite=1, alu_src=1 → ex_mem_store_data=32'hDEAD_BEEF, ex_mem_memwrite=1.
- Branches:
  - BLT with rs1=32'hFFFF_FFFF, rs2=1, pc=32'h100, imm=32'h20 → branch_taken=1, branch_target=32'h120 in the same cycle.
  - BLTU with the same operands → branch_taken=0.
- Stall then flush:
  - load an ADD result of 7; assert stall for 3 cycles with new inputs → outputs stay 7.
  - assert stall+flush → ex_mem_valid=0, ex_mem_regwrite=0.
- Async reset: rst_n low mid-cycle while ex_mem_regwrite=1 → all outputs 0 immediately, before the next clock edge, and ex_mem_pc=RESET_PC.
- EX_MUL_EN: opA=32'h0001_0000, opB=32'h0001_0003, op 1011 → 32'h0003_0000 when defined, 0 when undefined; SRA of 32'h8000_0000 by 4 → 32'hF800_0000.
